// File: rtl/event_count_arbiter.sv
// rtl/event_count_arbiter.sv - round-robin event accumulators sharing one multicycle counter adder
// Optional feature macro: EVENT_COUNT_ARB_CLEAR_EN (adds clr/clr_sel per-source clear)
module event_count_arbiter #(
   parameter int NUM_SRC           = 4,
   parameter int COUNTER_WIDTH     = 64,
   parameter int PENDING_WIDTH     = 4,
   parameter int CYCLES_PER_UPDATE = 2
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [NUM_SRC-1:0]          src_en,
   output logic [NUM_SRC-1:0]          src_ready,
   input  logic [$clog2(NUM_SRC)-1:0]  rd_sel,
`ifdef EVENT_COUNT_ARB_CLEAR_EN
   input  logic                        clr,
   input  logic [$clog2(NUM_SRC)-1:0]  clr_sel,
`endif
   output logic [COUNTER_WIDTH-1:0]    rd_count,
   output logic                        rd_valid,
   output logic                        idle
);

   localparam int IDX_W = $clog2(NUM_SRC);
   localparam int CYC_W = (CYCLES_PER_UPDATE > 1) ? $clog2(CYCLES_PER_UPDATE) : 1;
   localparam logic [PENDING_WIDTH-1:0] PEND_MAX = '1;
   localparam logic [CYC_W-1:0]         CYC_LAST = CYC_W'(CYCLES_PER_UPDATE - 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ADD   = 2'd1,
      ST_WRITE = 2'd2
   } state_e;

   state_e                     state_q, state_d;
   logic [COUNTER_WIDTH-1:0]   count_q   [NUM_SRC];
   logic [COUNTER_WIDTH-1:0]   count_d   [NUM_SRC];
   logic [PENDING_WIDTH-1:0]   pending_q [NUM_SRC];
   logic [PENDING_WIDTH-1:0]   pending_d [NUM_SRC];
   logic [IDX_W-1:0]           grant_q, grant_d;
   logic [IDX_W-1:0]           last_grant_q, last_grant_d;
   logic [COUNTER_WIDTH-1:0]   opnd_a_q, opnd_a_d;
   logic [PENDING_WIDTH-1:0]   opnd_b_q, opnd_b_d;
   logic [CYC_W-1:0]           cyc_q, cyc_d;
   logic                       clr_hit_q, clr_hit_d;

   logic [NUM_SRC-1:0]         accept;
   logic                       req_any;
   logic [IDX_W-1:0]           req_idx;
   logic                       do_grant;
   logic                       do_write;
   logic                       busy;
   logic                       clr_v;
   logic [IDX_W-1:0]           clr_idx;

`ifdef EVENT_COUNT_ARB_CLEAR_EN
   assign clr_v   = clr;
   assign clr_idx = clr_sel;
`else
   assign clr_v   = 1'b0;
   assign clr_idx = '0;
`endif

   // Per-source backpressure and accepted events; a cleared source drops its same-cycle event
   always_comb begin
      for (int i = 0; i < NUM_SRC; i++) begin
         src_ready[i] = rst & (pending_q[i] != PEND_MAX);
         accept[i]    = src_en[i] & src_ready[i];
         if (clr_v && (int'(clr_idx) == i)) begin
            accept[i] = 1'b0;
         end
      end
   end

   // Round-robin search starting just after the last serviced source; a clearing source is skipped
   always_comb begin
      int j;
      j       = 0;
      req_any = 1'b0;
      req_idx = '0;
      for (int k = 1; k <= NUM_SRC; k++) begin
         j = (int'(last_grant_q) + k) % NUM_SRC;
         if (!req_any && (pending_q[j] != '0) && !(clr_v && (int'(clr_idx) == j))) begin
            req_any = 1'b1;
            req_idx = IDX_W'(j);
         end
      end
   end

   // FSM state register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next state: grant, hold the operands for the multicycle add, then commit
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (req_any) state_d = ST_ADD;
         ST_ADD:   if (cyc_q == CYC_LAST) state_d = ST_WRITE;
         ST_WRITE: state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   // FSM outputs driving the shared datapath
   always_comb begin
      do_grant = (state_q == ST_IDLE) && req_any;
      do_write = (state_q == ST_WRITE);
      busy     = (state_q != ST_IDLE);
   end

   // Datapath next state: accumulate, snapshot on grant, write back, per-source clear
   always_comb begin
      grant_d      = grant_q;
      last_grant_d = last_grant_q;
      opnd_a_d     = opnd_a_q;
      opnd_b_d     = opnd_b_q;
      cyc_d        = cyc_q;
      clr_hit_d    = clr_hit_q;
      for (int i = 0; i < NUM_SRC; i++) begin
         pending_d[i] = pending_q[i] + PENDING_WIDTH'(accept[i]);
         count_d[i]   = count_q[i];
      end

      if (do_grant) begin
         grant_d            = req_idx;
         opnd_a_d           = count_q[req_idx];
         opnd_b_d           = pending_q[req_idx];
         pending_d[req_idx] = PENDING_WIDTH'(accept[req_idx]);
         cyc_d              = '0;
         clr_hit_d          = 1'b0;
      end

      if (state_q == ST_ADD) begin
         cyc_d = cyc_q + CYC_W'(1);
      end

      if (do_write) begin
         if (!clr_hit_q) begin
            count_d[grant_q] = opnd_a_q + COUNTER_WIDTH'(opnd_b_q);
         end
         last_grant_d = grant_q;
      end

      // Clear wins over a same-edge write-back and kills an in-flight batch of that source
      if (clr_v && (int'(clr_idx) < NUM_SRC)) begin
         count_d[clr_idx]   = '0;
         pending_d[clr_idx] = '0;
         if (busy && (clr_idx == grant_q)) begin
            clr_hit_d = 1'b1;
         end
      end
   end

   // Datapath registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < NUM_SRC; i++) begin
            count_q[i]   <= '0;
            pending_q[i] <= '0;
         end
         grant_q      <= '0;
         last_grant_q <= '0;
         opnd_a_q     <= '0;
         opnd_b_q     <= '0;
         cyc_q        <= '0;
         clr_hit_q    <= 1'b0;
      end else begin
         for (int i = 0; i < NUM_SRC; i++) begin
            count_q[i]   <= count_d[i];
            pending_q[i] <= pending_d[i];
         end
         grant_q      <= grant_d;
         last_grant_q <= last_grant_d;
         opnd_a_q     <= opnd_a_d;
         opnd_b_q     <= opnd_b_d;
         cyc_q        <= cyc_d;
         clr_hit_q    <= clr_hit_d;
      end
   end

   // Readout: committed count is only complete when nothing is pending or in flight for it
   always_comb begin
      rd_count = '0;
      rd_valid = 1'b1;
      if (int'(rd_sel) < NUM_SRC) begin
         rd_count = count_q[rd_sel];
         rd_valid = (pending_q[rd_sel] == '0) && !(busy && (grant_q == rd_sel));
      end
      idle = (state_q == ST_IDLE);
      for (int i = 0; i < NUM_SRC; i++) begin
         if (pending_q[i] != '0) begin
            idle = 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_event_count_arbiter.sv
// tb/tb_event_count_arbiter.sv - randomized self-checking bench with transaction-level reference model
module tb_event_count_arbiter;

   localparam int NS   = 4;
   localparam int CW   = 8;
   localparam int PW   = 4;
   localparam int CPU  = 2;
   localparam int PMAX = (1 << PW) - 1;
   localparam int CMOD = 1 << CW;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic [NS-1:0] src_en = '0;
   logic [NS-1:0] src_ready;
   logic [1:0]    rd_sel = '0;
   logic          clr = 1'b0;
   logic [1:0]    clr_sel = '0;
   logic [CW-1:0] rd_count;
   logic          rd_valid;
   logic          idle;

   int n_checks = 0;
   int n_errors = 0;

   // reference model: pending counts, committed counts, events owed, one in-flight batch
   int m_pend  [NS];
   int m_cnt   [NS];
   int m_total [NS];
   int m_timer;
   int m_src;
   int m_amt;
   int m_last;
   bit m_kill;

   event_count_arbiter #(
      .NUM_SRC(NS), .COUNTER_WIDTH(CW), .PENDING_WIDTH(PW), .CYCLES_PER_UPDATE(CPU)
   ) dut (
      .clk(clk),
      .rst(rst),
      .src_en(src_en),
      .src_ready(src_ready),
      .rd_sel(rd_sel),
`ifdef EVENT_COUNT_ARB_CLEAR_EN
      .clr(clr),
      .clr_sel(clr_sel),
`endif
      .rd_count(rd_count),
      .rd_valid(rd_valid),
      .idle(idle)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   function automatic bit model_idle();
      bit r;
      r = (m_timer == 0);
      for (int i = 0; i < NS; i++) if (m_pend[i] != 0) r = 0;
      return r;
   endfunction

   function automatic logic [NS-1:0] model_ready();
      logic [NS-1:0] r;
      for (int i = 0; i < NS; i++) r[i] = (m_pend[i] != PMAX);
      return r;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < NS; i++) begin
         m_pend[i] = 0; m_cnt[i] = 0; m_total[i] = 0;
      end
      m_timer = 0; m_src = 0; m_amt = 0; m_last = 0; m_kill = 0;
   endtask

   // one clock: drive, compare against model, advance both at the edge
   task automatic step(input logic [NS-1:0] en, input int sel);
      logic [NS-1:0] acc;
      int g;
      int c;
      src_en = en;
      rd_sel = sel[1:0];
      #1;
      check("src_ready", src_ready, model_ready());
      check("idle", idle, model_idle());
      check("rd_count", rd_count, m_cnt[sel]);
      check("rd_valid", rd_valid, (m_pend[sel] == 0) && !(m_timer != 0 && m_src == sel));
      for (int i = 0; i < NS; i++)
         acc[i] = en[i] && (m_pend[i] != PMAX) && !(clr && int'(clr_sel) == i);
      @(posedge clk);
      g = -1;
      if (m_timer == 0) begin
         for (int k = 1; k <= NS; k++) begin
            int j;
            j = (m_last + k) % NS;
            if (g < 0 && m_pend[j] != 0 && !(clr && int'(clr_sel) == j)) g = j;
         end
         if (g >= 0) begin
            m_src = g; m_amt = m_pend[g]; m_kill = 0; m_timer = CPU + 1;
         end
      end else begin
         m_timer--;
         if (m_timer == 0) begin
            if (!m_kill && !(clr && int'(clr_sel) == m_src))
               m_cnt[m_src] = (m_cnt[m_src] + m_amt) % CMOD;
            m_last = m_src;
         end
      end
      for (int i = 0; i < NS; i++) begin
         if (i == g) m_pend[i] = int'(acc[i]);
         else        m_pend[i] = m_pend[i] + int'(acc[i]);
         m_total[i] = m_total[i] + int'(acc[i]);
      end
      if (clr) begin
         c = int'(clr_sel);
         if (m_timer != 0 && m_src == c) m_kill = 1;
         m_cnt[c] = 0; m_pend[c] = 0; m_total[c] = 0;
      end
      @(negedge clk);
   endtask

   task automatic do_reset();
      src_en = '0; clr = 1'b0; clr_sel = '0;
      rst = 1'b0;
      @(negedge clk);
      #1;
      check("rst_ready", src_ready, 0);
      check("rst_valid", rd_valid, 1);
      check("rst_idle", idle, 1);
      for (int i = 0; i < NS; i++) begin
         rd_sel = 2'(i);
         #0.5;
         check("rst_count", rd_count, 0);
      end
      @(negedge clk);
      rst = 1'b1;
      model_reset();
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (!model_idle() && n < 200) begin
         step('0, int'($urandom_range(0, NS - 1)));
         n++;
      end
      check("drain_bound", n < 200, 1);
      step('0, 0);
   endtask

   // every accepted event must end up in the committed count once idle
   task automatic final_check();
      for (int i = 0; i < NS; i++) begin
         rd_sel = 2'(i);
         #0.5;
         check("final_count", rd_count, m_total[i] % CMOD);
         check("final_valid", rd_valid, 1);
      end
      @(negedge clk);
   endtask

   initial begin
      bit sat_seen;
      int n;
      model_reset();
      @(negedge clk);
      do_reset();

      // single event: visible four cycles after acceptance
      #1;
      check("post_rst_ready", src_ready, 4'hF);
      step(4'b0001, 0);
      for (int i = 0; i < 3; i++) step('0, 0);
      #1;
      check("single_count_early", rd_count, 0);
      step('0, 0);
      #1;
      check("single_count", rd_count, 1);
      check("single_valid", rd_valid, 1);
      check("single_idle", idle, 1);
      drain();

      // accept coinciding with the grant edge is kept for the next batch
      do_reset();
      step(4'b0010, 1);
      drain();
      step(4'b0011, 1);
      for (int i = 0; i < 5; i++) step(4'b0010, 1);
      for (int i = 0; i < 3; i++) step('0, 1);
      #1;
      check("simul_first", rd_count, 6);
      check("simul_first_valid", rd_valid, 0);
      drain();
      rd_sel = 2'd1;
      #1;
      check("simul_count", rd_count, 7);
      final_check();

      // all sources streaming: fairness plus backpressure on the pending accumulators
      do_reset();
      sat_seen = 0;
      for (int i = 0; i < 40; i++) begin
         step(4'b1111, i % NS);
         if (!src_ready[2]) sat_seen = 1;
      end
      check("sat_seen", sat_seen, 1);
      drain();
      final_check();

      // counter wrap: 258 events into an 8-bit count
      do_reset();
      n = 0;
      while (m_total[3] < 258 && n < 600) begin
         step(4'b1000, 3);
         n++;
      end
      check("wrap_bound", n < 600, 1);
      drain();
      rd_sel = 2'd3;
      #1;
      check("wrap_count", rd_count, 2);
      final_check();

      // random traffic
      do_reset();
      for (int i = 0; i < 300; i++)
         step(4'($urandom_range(0, 15)), int'($urandom_range(0, NS - 1)));
      drain();
      final_check();

      // reset in the middle of a batch must abort it
      for (int i = 0; i < 6; i++) step(4'b1111, 0);
      do_reset();

`ifdef EVENT_COUNT_ARB_CLEAR_EN
      // clear of the source whose batch of three is in the add phase
      step(4'b0010, 0);
      for (int i = 0; i < 3; i++) step(4'b0001, 0);
      step('0, 0);
      step('0, 0);
      clr = 1'b1; clr_sel = 2'd0;
      step('0, 0);
      clr = 1'b0;
      drain();
      rd_sel = 2'd0;
      #1;
      check("clr_count0", rd_count, 0);
      rd_sel = 2'd1;
      #1;
      check("clr_count1", rd_count, 1);
      final_check();
      for (int i = 0; i < 200; i++) begin
         clr = ($urandom_range(0, 7) == 0);
         clr_sel = 2'($urandom_range(0, NS - 1));
         step(4'($urandom_range(0, 15)), int'($urandom_range(0, NS - 1)));
      end
      clr = 1'b0;
      drain();
      final_check();
`endif

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
